mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/core_pkg.sv | 20 ++
 rtl/arb_timeout_ctr.sv | 40 ++++
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types for the memory arbiter: FSM states, port identifiers and
// the counter-width helper used by the timeout counter.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } arb_port_t;

    function automatic int ctr_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/arb_timeout_ctr.sv
// Wait counter for one memory access: cleared on grant, counts BUSY cycles
// without a response, and flags the cycle in which the count reaches TIMEOUT.
module arb_timeout_ctr
    import core_pkg::*;
#(
    parameter int TIMEOUT = 255
)(
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int            CW   = ctr_width(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The increment happening this cycle is the one that reaches TIMEOUT.
    assign expire_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single memory port, with a
// per-access response timeout.
//   state | meaning
//   IDLE  | no access in flight; arbitrate eligible requesters
//   BUSY0 | port 0 (fetch) read in flight
//   BUSY1 | port 1 (data) read or write in flight
module mem_arbiter
    import core_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             c0_req,
    input  logic [WIDTH-1:0] c0_addr,
    output logic             c0_resp,
    output logic [WIDTH-1:0] c0_rdata,
    output logic             c0_err,
    input  logic             c1_req,
    input  logic             c1_we,
    input  logic [WIDTH-1:0] c1_addr,
    input  logic [WIDTH-1:0] c1_wdata,
    output logic             c1_resp,
    output logic [WIDTH-1:0] c1_rdata,
    output logic             c1_err,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_read,
    output logic             mem_write,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_resp
);

    arb_state_t       state_q, state_d;
    arb_port_t        last_grant_q, last_grant_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             we_q, we_d;
    logic             c0_resp_q, c0_resp_d, c1_resp_q, c1_resp_d;
    logic             c0_err_q, c0_err_d, c1_err_q, c1_err_d;
    logic             elig0, elig1, grant, busy, ctr_en, expire;

    // A requester still showing its completion pulse has not dropped req yet.
    assign elig0  = c0_req && !c0_resp_q && !c0_err_q;
    assign elig1  = c1_req && !c1_resp_q && !c1_err_q;
    assign busy   = (state_q != IDLE);
    assign ctr_en = busy && !mem_resp;

    arb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (grant),
        .enable_i (ctr_en),
        .expire_o (expire)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        rdata_d      = rdata_q;
        c0_resp_d    = 1'b0;
        c1_resp_d    = 1'b0;
        c0_err_d     = 1'b0;
        c1_err_d     = 1'b0;
        grant        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (elig0 && (!elig1 || last_grant_q == PORT1)) begin
                    grant        = 1'b1;
                    state_d      = BUSY0;
                    last_grant_d = PORT0;
                    addr_d       = c0_addr;
                    wdata_d      = '0;
                    we_d         = 1'b0;
                end else if (elig1) begin
                    grant        = 1'b1;
                    state_d      = BUSY1;
                    last_grant_d = PORT1;
                    addr_d       = c1_addr;
                    wdata_d      = c1_wdata;
                    we_d         = c1_we;
                end
            end
            BUSY0, BUSY1: begin
                // A response arriving with the final counted cycle still wins.
                if (mem_resp) begin
                    state_d   = IDLE;
                    rdata_d   = mem_rdata;
                    c0_resp_d = (state_q == BUSY0);
                    c1_resp_d = (state_q == BUSY1);
                end else if (expire) begin
                    state_d  = IDLE;
                    c0_err_d = (state_q == BUSY0);
                    c1_err_d = (state_q == BUSY1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= PORT1;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            rdata_q      <= '0;
            c0_resp_q    <= 1'b0;
            c1_resp_q    <= 1'b0;
            c0_err_q     <= 1'b0;
            c1_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            rdata_q      <= rdata_d;
            c0_resp_q    <= c0_resp_d;
            c1_resp_q    <= c1_resp_d;
            c0_err_q     <= c0_err_d;
            c1_err_q     <= c1_err_d;
        end
    end

    assign mem_read  = (state_q == BUSY0) || ((state_q == BUSY1) && !we_q);
    assign mem_write = (state_q == BUSY1) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign c0_resp   = c0_resp_q;
    assign c1_resp   = c1_resp_q;
    assign c0_err    = c0_err_q;
    assign c1_err    = c1_err_q;
    assign c0_rdata  = rdata_q;
    assign c1_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed client requests, a latency-
// programmable memory model, and a negedge monitor checking accesses/responses.
module tb_mem_arbiter;

    localparam int W   = 32;
    localparam int TMO = 4;

    localparam logic [3:0] K_R0 = 4'b0001;
    localparam logic [3:0] K_E0 = 4'b0010;
    localparam logic [3:0] K_R1 = 4'b0100;

    logic         clk = 1'b0;
    logic         rst;
    logic         c0_req, c0_resp, c0_err;
    logic [W-1:0] c0_addr, c0_rdata;
    logic         c1_req, c1_we, c1_resp, c1_err;
    logic [W-1:0] c1_addr, c1_wdata, c1_rdata;
    logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
    logic         mem_read, mem_write, mem_resp;

    always #5 clk = ~clk;

    mem_arbiter #(.WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .c0_req    (c0_req),
        .c0_addr   (c0_addr),
        .c0_resp   (c0_resp),
        .c0_rdata  (c0_rdata),
        .c0_err    (c0_err),
        .c1_req    (c1_req),
        .c1_we     (c1_we),
        .c1_addr   (c1_addr),
        .c1_wdata  (c1_wdata),
        .c1_resp   (c1_resp),
        .c1_rdata  (c1_rdata),
        .c1_err    (c1_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata),
        .mem_resp  (mem_resp)
    );

    typedef struct {
        logic         we;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
        int           len;
        int           gap;
    } acc_t;

    typedef struct {
        logic [3:0]   kind;
        logic [W-1:0] rdata;
        bit           chk;
    } rsp_t;

    typedef struct {
        logic         we;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
    } cli_t;

    acc_t acc_q[$];
    rsp_t rsp_q[$];
    cli_t cli0_q[$];
    cli_t cli1_q[$];

    int           n_checks = 0;
    int           n_fail = 0;
    int           stall_cnt = 0;
    bit           done = 1'b0;
    int           lat = 0;
    bit           rd_fixed_en = 1'b0;
    logic [W-1:0] rd_fixed = '0;
    bit           idle_resp = 1'b0;
    int           scnt = 0;
    bit           drop0 = 1'b0;
    bit           drop1 = 1'b0;

    function automatic void push_acc(input logic we, input logic [W-1:0] addr,
                                     input logic [W-1:0] wdata, input int len, input int gap);
        acc_t a;
        a.we = we; a.addr = addr; a.wdata = wdata; a.len = len; a.gap = gap;
        acc_q.push_back(a);
    endfunction

    function automatic void push_rsp(input logic [3:0] kind, input logic [W-1:0] rdata, input bit chk);
        rsp_t r;
        r.kind = kind; r.rdata = rdata; r.chk = chk;
        rsp_q.push_back(r);
    endfunction

    function automatic void push_cli(input bit port, input logic we, input logic [W-1:0] addr,
                                     input logic [W-1:0] wdata);
        cli_t c;
        c.we = we; c.addr = addr; c.wdata = wdata;
        if (port) cli1_q.push_back(c);
        else      cli0_q.push_back(c);
    endfunction

    // One clock: clients drop req the edge after their pulse, pick up queued
    // requests, and the memory model answers after `lat` strobe cycles.
    task automatic tick();
        @(posedge clk);
        #1;
        if (drop0) begin c0_req = 1'b0; drop0 = 1'b0; end
        if (drop1) begin c1_req = 1'b0; drop1 = 1'b0; end
        if (c0_resp || c0_err) drop0 = 1'b1;
        if (c1_resp || c1_err) drop1 = 1'b1;
        if (!c0_req && cli0_q.size() > 0) begin
            cli_t r;
            r = cli0_q.pop_front();
            c0_req = 1'b1; c0_addr = r.addr;
        end
        if (!c1_req && cli1_q.size() > 0) begin
            cli_t r;
            r = cli1_q.pop_front();
            c1_req = 1'b1; c1_we = r.we; c1_addr = r.addr; c1_wdata = r.wdata;
        end
        if (mem_read || mem_write) begin
            mem_resp  = (lat >= 0) && (scnt == lat);
            mem_rdata = rd_fixed_en ? rd_fixed : ~mem_addr;
            scnt++;
        end else begin
            scnt      = 0;
            mem_resp  = idle_resp;
            mem_rdata = '0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        c0_req = 1'b0; c1_req = 1'b0; drop0 = 1'b0; drop1 = 1'b0;
        mem_resp = 1'b0; scnt = 0;
        cli0_q.delete(); cli1_q.delete();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || acc_q.size() != 0 || cli0_q.size() != 0 ||
                cli1_q.size() != 0 || c0_req || c1_req || mem_read || mem_write) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) stall_cnt++;
        repeat (4) tick();
    endtask

    initial begin : stim
        int n;
        c0_req = 1'b0; c0_addr = '0;
        c1_req = 1'b0; c1_we = 1'b0; c1_addr = '0; c1_wdata = '0;
        mem_rdata = '0; mem_resp = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // c0 read 0x100, response on the 4th strobe cycle (also the expiry cycle)
        lat = 3; rd_fixed_en = 1'b1; rd_fixed = 32'hDEADBEEF;
        push_acc(1'b0, 32'h100, '0, 4, -1);
        push_rsp(K_R0, 32'hDEADBEEF, 1'b1);
        push_cli(1'b0, 1'b0, 32'h100, '0);
        wait_done(60);
        rd_fixed_en = 1'b0;

        // after reset, simultaneous requests: c0, c1, c0 with one bubble each
        do_reset();
        lat = 1;
        push_acc(1'b0, 32'h200, '0, 2, -1);
        push_acc(1'b0, 32'h300, '0, 2, 1);
        push_acc(1'b0, 32'h204, '0, 2, 1);
        push_rsp(K_R0, 32'hFFFFFDFF, 1'b1);
        push_rsp(K_R1, 32'hFFFFFCFF, 1'b1);
        push_rsp(K_R0, 32'hFFFFFDFB, 1'b1);
        push_cli(1'b0, 1'b0, 32'h200, '0);
        push_cli(1'b0, 1'b0, 32'h204, '0);
        push_cli(1'b1, 1'b0, 32'h300, '0);
        wait_done(80);

        // c1 write
        lat = 2;
        push_acc(1'b1, 32'h40, 32'h12345678, 3, -1);
        push_rsp(K_R1, '0, 1'b0);
        push_cli(1'b1, 1'b1, 32'h40, 32'h12345678);
        wait_done(60);

        // c0 timeout
        lat = -1;
        push_acc(1'b0, 32'h80, '0, 4, -1);
        push_rsp(K_E0, '0, 1'b0);
        push_cli(1'b0, 1'b0, 32'h80, '0);
        wait_done(60);

        // tie after a c0 grant: c1 wins, then c0
        lat = 0;
        push_acc(1'b0, 32'h14, '0, 1, -1);
        push_acc(1'b0, 32'h10, '0, 1, 1);
        push_rsp(K_R1, 32'hFFFFFFEB, 1'b1);
        push_rsp(K_R0, 32'hFFFFFFEF, 1'b1);
        push_cli(1'b0, 1'b0, 32'h10, '0);
        push_cli(1'b1, 1'b0, 32'h14, '0);
        wait_done(60);

        // stray mem_resp while idle, then a normal c1 read
        idle_resp = 1'b1;
        repeat (5) tick();
        idle_resp = 1'b0;
        push_acc(1'b0, 32'h50, '0, 1, -1);
        push_rsp(K_R1, 32'hFFFFFFAF, 1'b1);
        push_cli(1'b1, 1'b0, 32'h50, '0);
        wait_done(60);

        // reset in the middle of a c1 read: no resp or err afterwards
        lat = -1;
        push_acc(1'b0, 32'h60, '0, -1, -1);
        push_cli(1'b1, 1'b0, 32'h60, '0);
        n = 0;
        while (!mem_read && n < 20) begin tick(); n++; end
        if (!mem_read) stall_cnt++;
        tick();
        do_reset();
        wait_done(40);

        done = 1'b1;
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        bit         prev_s;
        bit         s;
        int         idle_cnt;
        int         cur_len;
        acc_t       cur;
        rsp_t       r;
        logic [3:0] kind;
        prev_s = 1'b0; idle_cnt = 1000; cur_len = 0;
        cur.we = 1'b0; cur.addr = '0; cur.wdata = '0; cur.len = -1; cur.gap = -1;
        forever begin
            @(negedge clk);
            s    = mem_read || mem_write;
            kind = {c1_err, c1_resp, c0_err, c0_resp};
            if (rst) begin
                chk("reset_strobes_flags", W'({mem_read, mem_write, kind}), '0);
                chk("reset_rdata", c0_rdata, '0);
                chk("reset_addr", mem_addr, '0);
                prev_s = 1'b0; idle_cnt = 1000; cur_len = 0;
            end else begin
                if (kind != 4'b0000) begin
                    if (rsp_q.size() == 0) begin
                        chk("unexpected_resp", W'(kind), '0);
                    end else begin
                        r = rsp_q.pop_front();
                        chk("resp_kind", W'(kind), W'(r.kind));
                        if (r.chk) chk("resp_rdata", r.kind[2] ? c1_rdata : c0_rdata, r.rdata);
                    end
                end
                if (s && !prev_s) begin
                    cur_len = 1;
                    if (acc_q.size() == 0) begin
                        chk("unexpected_strobe", W'({mem_read, mem_write}), '0);
                        cur.we = mem_write; cur.addr = mem_addr; cur.wdata = mem_wdata;
                        cur.len = -1; cur.gap = -1;
                    end else begin
                        cur = acc_q.pop_front();
                        chk("acc_addr", mem_addr, cur.addr);
                        chk("acc_rd_wr", W'({mem_read, mem_write}), W'({!cur.we, cur.we}));
                        if (cur.we) chk("acc_wdata", mem_wdata, cur.wdata);
                        if (cur.gap >= 0) chk("acc_gap", W'(idle_cnt), W'(cur.gap));
                    end
                end else if (s && prev_s) begin
                    cur_len++;
                    chk("hold_addr", mem_addr, cur.addr);
                    if (cur.we) chk("hold_wdata", mem_wdata, cur.wdata);
                end else if (!s && prev_s) begin
                    if (cur.len >= 0) chk("acc_len", W'(cur_len), W'(cur.len));
                end
                idle_cnt = s ? 0 : idle_cnt + 1;
                prev_s   = s;
            end
            if (done) begin
                chk("rsp_queue_drained", W'(rsp_q.size()), '0);
                chk("acc_queue_drained", W'(acc_q.size()), '0);
                chk("wait_budget", W'(stall_cnt), '0);
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $finish;
            end
        end
    end

endmodule
